// File: rtl/mdu_ctrl_pkg.sv
// Shared definitions for the multiply/divide sequencer: op codes, FSM
// encodings, divider context flags and operand helpers.
package mdu_ctrl_pkg;

    localparam int unsigned MDU_OP_WD = 3;

    localparam logic [2:0] MDU_OP_MULT  = 3'd0;
    localparam logic [2:0] MDU_OP_MULTU = 3'd1;
    localparam logic [2:0] MDU_OP_DIV   = 3'd2;
    localparam logic [2:0] MDU_OP_DIVU  = 3'd3;
    localparam logic [2:0] MDU_OP_MTHI  = 3'd4;
    localparam logic [2:0] MDU_OP_MTLO  = 3'd5;

    localparam logic [1:0] MDU_ST_IDLE    = 2'd0;
    localparam logic [1:0] MDU_ST_MUL     = 2'd1;
    localparam logic [1:0] MDU_ST_DIV_RUN = 2'd2;
    localparam logic [1:0] MDU_ST_DIV_FIX = 2'd3;

    typedef struct packed {
        logic q_neg;
        logic r_neg;
        logic div_zero;
    } div_flags_t;

    function automatic logic [31:0] mag32(input logic [31:0] value, input logic is_signed);
        mag32 = (is_signed && value[31]) ? (~value + 32'd1) : value;
    endfunction

    function automatic logic [31:0] cond_neg32(input logic [31:0] value, input logic neg);
        cond_neg32 = neg ? (~value + 32'd1) : value;
    endfunction

endpackage

// File: rtl/mdu_ctrl_if.sv
// Request/result bundle between the EX stage (master) and the MDU (slave).
interface mdu_ctrl_if;
    import mdu_ctrl_pkg::*;

    logic                 start;
    logic [MDU_OP_WD-1:0] op;
    logic [31:0]          src_a;
    logic [31:0]          src_b;
    logic                 cancel;
    logic                 stallreq;
    logic                 busy;
    logic                 done;
    logic [31:0]          hi;
    logic [31:0]          lo;

    modport master (
        output start, op, src_a, src_b, cancel,
        input  stallreq, busy, done, hi, lo
    );

    modport slave (
        input  start, op, src_a, src_b, cancel,
        output stallreq, busy, done, hi, lo
    );

endinterface

// File: rtl/mdu_div_step.sv
// One restoring-division iteration on the packed {rem,quo} register.
module mdu_div_step (
    input  logic [63:0] i_rq,
    input  logic [31:0] i_divisor,
    output logic [63:0] o_rq
);

    logic [63:0] w_shifted;
    logic [31:0] w_diff;
    logic        w_fits;

    assign w_shifted = {i_rq[62:0], 1'b0};
    // The bit shifted out of rem takes part in the compare, hence 33 bits.
    assign w_fits    = {i_rq[63], w_shifted[63:32]} >= {1'b0, i_divisor};
    assign w_diff    = w_shifted[63:32] - i_divisor;

    // Select restored or subtracted remainder and record the quotient bit.
    always_comb begin
        if (w_fits) begin
            o_rq = {w_diff, w_shifted[31:1], 1'b1};
        end else begin
            o_rq = w_shifted;
        end
    end

endmodule

// File: rtl/mdu_ctrl.sv
// EX-stage multiply/divide sequencer: owns HI/LO, runs a one-cycle multiplier
// and a 32-step restoring divider, and stalls the pipeline while busy.
module mdu_ctrl
    import mdu_ctrl_pkg::*;
#(
    parameter int unsigned DIV_STEPS = 32
) (
    input  logic       clk,
    input  logic       rst,
    mdu_ctrl_if.slave  bus
);

    localparam int             STEP_W    = $clog2(DIV_STEPS);
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(DIV_STEPS - 1);

    logic [1:0]        r_state;
    logic [STEP_W-1:0] r_step;
    logic [31:0]       r_opa;
    logic [31:0]       r_opb;
    logic              r_mul_signed;
    logic [63:0]       r_rq;
    logic [31:0]       r_divisor;
    div_flags_t        r_flags;
    logic [31:0]       r_hi;
    logic [31:0]       r_lo;
    logic              r_done;

    logic              w_busy;
    logic              w_accept;
    logic              w_div_signed;
    logic              w_mul_signed;
    logic signed [32:0] w_mul_a;
    logic signed [32:0] w_mul_b;
    logic signed [63:0] w_prod;
    logic [63:0]       w_next_rq;
    logic [31:0]       w_fix_q;
    logic [31:0]       w_fix_r;

    assign w_busy       = (r_state != MDU_ST_IDLE);
    // The completed instruction is still in EX during the done cycle.
    assign w_accept     = !w_busy && bus.start && !r_done && !bus.cancel;
    assign w_div_signed = (bus.op == MDU_OP_DIV);
    assign w_mul_signed = (bus.op == MDU_OP_MULT);

    assign w_mul_a = $signed({r_mul_signed & r_opa[31], r_opa});
    assign w_mul_b = $signed({r_mul_signed & r_opb[31], r_opb});
    assign w_prod  = 64'(w_mul_a) * 64'(w_mul_b);

    assign w_fix_q = cond_neg32(r_rq[31:0],  r_flags.q_neg);
    assign w_fix_r = cond_neg32(r_rq[63:32], r_flags.r_neg);

    mdu_div_step u_div_step (
        .i_rq      (r_rq),
        .i_divisor (r_divisor),
        .o_rq      (w_next_rq)
    );

    // Sequencer FSM, operand latches and the architectural HI/LO registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= MDU_ST_IDLE;
            r_step       <= '0;
            r_opa        <= 32'd0;
            r_opb        <= 32'd0;
            r_mul_signed <= 1'b0;
            r_rq         <= 64'd0;
            r_divisor    <= 32'd0;
            r_flags      <= '0;
            r_hi         <= 32'd0;
            r_lo         <= 32'd0;
            r_done       <= 1'b0;
        end else if (bus.cancel) begin
            r_state <= MDU_ST_IDLE;
            r_step  <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                MDU_ST_IDLE: begin
                    if (w_accept) begin
                        case (bus.op)
                            MDU_OP_MULT, MDU_OP_MULTU: begin
                                r_opa        <= bus.src_a;
                                r_opb        <= bus.src_b;
                                r_mul_signed <= w_mul_signed;
                                r_state      <= MDU_ST_MUL;
                            end
                            MDU_OP_DIV, MDU_OP_DIVU: begin
                                r_opa            <= bus.src_a;
                                r_rq             <= {32'd0, mag32(bus.src_a, w_div_signed)};
                                r_divisor        <= mag32(bus.src_b, w_div_signed);
                                r_flags.q_neg    <= w_div_signed & (bus.src_a[31] ^ bus.src_b[31]);
                                r_flags.r_neg    <= w_div_signed & bus.src_a[31];
                                r_flags.div_zero <= (bus.src_b == 32'd0);
                                r_step           <= '0;
                                r_state          <= MDU_ST_DIV_RUN;
                            end
                            MDU_OP_MTHI: r_hi <= bus.src_a;
                            MDU_OP_MTLO: r_lo <= bus.src_a;
                            default:     r_state <= MDU_ST_IDLE;
                        endcase
                    end
                end
                MDU_ST_MUL: begin
                    {r_hi, r_lo} <= w_prod;
                    r_done       <= 1'b1;
                    r_state      <= MDU_ST_IDLE;
                end
                MDU_ST_DIV_RUN: begin
                    r_rq <= w_next_rq;
                    if (r_step == LAST_STEP) begin
                        r_step  <= '0;
                        r_state <= MDU_ST_DIV_FIX;
                    end else begin
                        r_step <= r_step + STEP_W'(1);
                    end
                end
                MDU_ST_DIV_FIX: begin
                    if (r_flags.div_zero) begin
                        r_hi <= r_opa;
                        r_lo <= 32'hFFFF_FFFF;
                    end else begin
                        r_hi <= w_fix_r;
                        r_lo <= w_fix_q;
                    end
                    r_done  <= 1'b1;
                    r_state <= MDU_ST_IDLE;
                end
                default: r_state <= MDU_ST_IDLE;
            endcase
        end
    end

    assign bus.busy     = w_busy;
    assign bus.done     = r_done;
    assign bus.hi       = r_hi;
    assign bus.lo       = r_lo;
    assign bus.stallreq = w_busy | (bus.start & ~bus.op[2] & ~r_done);

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: directed and random MULT/DIV/MTHI/MTLO
// traffic compared against a plain-arithmetic reference model.
module tb_mdu_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    mdu_ctrl_if bus ();

    mdu_ctrl #(.DIV_STEPS(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Returns {hi,lo} as the architecture defines them.
    function automatic logic [63:0] ref_result(input logic [2:0] o, input logic [31:0] a,
                                               input logic [31:0] b);
        longint      sa, sb, sq, sr;
        logic [63:0] ua, ub, res;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (o)
            3'd0: res = sa * sb;
            3'd1: res = ua * ub;
            3'd2: begin
                if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
                else begin
                    sq  = sa / sb;
                    sr  = sa % sb;
                    res = {sr[31:0], sq[31:0]};
                end
            end
            3'd3: begin
                if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
                else res = {32'(ua % ub), 32'(ua / ub)};
            end
            default: res = 64'd0;
        endcase
        return res;
    endfunction

    function automatic logic [31:0] pick_operand();
        int unsigned r;
        r = $urandom_range(0, 7);
        case (r)
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    // Issue one op at posedge+1 and wait (bounded) for done.
    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output int stalls, output logic [63:0] res);
        bus.start = 1'b1; bus.op = o; bus.src_a = a; bus.src_b = b;
        @(negedge clk);
        stalls = bus.stallreq ? 1 : 0;
        @(posedge clk); #1;
        bus.start = 1'b0;
        lat = 0;
        res = 64'd0;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            if (bus.stallreq) stalls++;
            if (bus.done) begin
                lat = i;
                res = {bus.hi, bus.lo};
                break;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; bus.start = 1'b0; bus.cancel = 1'b0; bus.op = 3'd0;
        bus.src_a = 32'd0; bus.src_b = 32'd0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.hi, bus.lo, bus.busy, bus.done, bus.stallreq} !== 67'd0) begin
            errors++;
            $display("FAIL reset_state got hi=%h lo=%h busy=%b done=%b stall=%b exp all zero",
                     bus.hi, bus.lo, bus.busy, bus.done, bus.stallreq);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_mul();
        logic [2:0]  ops [10];
        logic [31:0] as [10];
        logic [31:0] bs [10];
        logic [63:0] exp_v [10];
        logic [63:0] res;
        int          lat, st;
        ops[0] = 3'd0; as[0] = 32'hFFFF_FFFE; bs[0] = 32'd3; exp_v[0] = 64'hFFFF_FFFF_FFFF_FFFA;
        ops[1] = 3'd1; as[1] = 32'hFFFF_FFFE; bs[1] = 32'd3; exp_v[1] = 64'h0000_0002_FFFF_FFFA;
        for (int k = 2; k < 10; k++) begin
            ops[k] = (k % 2 == 1) ? 3'd1 : 3'd0;
            as[k]  = pick_operand();
            bs[k]  = pick_operand();
            exp_v[k] = ref_result(ops[k], as[k], bs[k]);
        end
        for (int k = 0; k < 10; k++) begin
            run_op(ops[k], as[k], bs[k], lat, st, res);
            checks++;
            if (lat !== 2) begin
                errors++; $display("FAIL mul_latency[%0d] got %0d exp 2", k, lat);
            end
            checks++;
            if (st !== 2) begin
                errors++; $display("FAIL mul_stalls[%0d] got %0d exp 2", k, st);
            end
            checks++;
            if (res !== exp_v[k]) begin
                errors++; $display("FAIL mul_result[%0d] got %h exp %h", k, res, exp_v[k]);
            end
            {m_hi, m_lo} = exp_v[k];
        end
    endtask

    task automatic test_div();
        logic [2:0]  ops [14];
        logic [31:0] as [14];
        logic [31:0] bs [14];
        logic [63:0] exp_v [14];
        logic [63:0] res;
        int          lat, st;
        ops[0] = 3'd2; as[0] = 32'hFFFF_FFF9; bs[0] = 32'd2;          exp_v[0] = 64'hFFFF_FFFF_FFFF_FFFD;
        ops[1] = 3'd3; as[1] = 32'd100;       bs[1] = 32'd7;          exp_v[1] = 64'h0000_0002_0000_000E;
        ops[2] = 3'd3; as[2] = 32'd5;         bs[2] = 32'd0;          exp_v[2] = 64'h0000_0005_FFFF_FFFF;
        ops[3] = 3'd2; as[3] = 32'h8000_0000; bs[3] = 32'hFFFF_FFFF;  exp_v[3] = 64'h0000_0000_8000_0000;
        ops[4] = 3'd2; as[4] = 32'hFFFF_FFF9; bs[4] = 32'd0;          exp_v[4] = 64'hFFFF_FFF9_FFFF_FFFF;
        ops[5] = 3'd2; as[5] = 32'd7;         bs[5] = 32'hFFFF_FFFE;  exp_v[5] = 64'h0000_0001_FFFF_FFFD;
        for (int k = 6; k < 14; k++) begin
            ops[k] = (k % 2 == 1) ? 3'd3 : 3'd2;
            as[k]  = pick_operand();
            bs[k]  = pick_operand();
            exp_v[k] = ref_result(ops[k], as[k], bs[k]);
        end
        for (int k = 0; k < 14; k++) begin
            run_op(ops[k], as[k], bs[k], lat, st, res);
            checks++;
            if (lat !== 34) begin
                errors++; $display("FAIL div_latency[%0d] got %0d exp 34", k, lat);
            end
            checks++;
            if (st !== 34) begin
                errors++; $display("FAIL div_stalls[%0d] got %0d exp 34", k, st);
            end
            checks++;
            if (res !== exp_v[k]) begin
                errors++; $display("FAIL div_result[%0d] op=%0d a=%h b=%h got %h exp %h",
                                   k, ops[k], as[k], bs[k], res, exp_v[k]);
            end
            {m_hi, m_lo} = exp_v[k];
        end
    endtask

    task automatic test_mthi_mtlo();
        bus.start = 1'b1; bus.op = 3'd4; bus.src_a = 32'h1234; bus.src_b = $urandom;
        @(negedge clk);
        checks++;
        if (bus.stallreq !== 1'b0) begin
            errors++; $display("FAIL mthi_stall got %b exp 0", bus.stallreq);
        end
        @(posedge clk); #1;
        bus.op = 3'd5; bus.src_a = 32'h5678;
        @(negedge clk);
        checks++;
        if ({bus.hi, bus.stallreq, bus.busy, bus.done} !== {32'h1234, 3'b000}) begin
            errors++; $display("FAIL mthi_write got hi=%h stall=%b busy=%b done=%b exp hi=00001234 0 0 0",
                               bus.hi, bus.stallreq, bus.busy, bus.done);
        end
        @(posedge clk); #1;
        bus.op = 3'd6; bus.src_a = 32'hDEAD_BEEF;
        @(negedge clk);
        checks++;
        if ({bus.hi, bus.lo, bus.stallreq} !== {32'h1234, 32'h5678, 1'b0}) begin
            errors++; $display("FAIL mtlo_write got hi=%h lo=%h stall=%b exp 00001234 00005678 0",
                               bus.hi, bus.lo, bus.stallreq);
        end
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.hi, bus.lo, bus.busy, bus.done} !== {32'h1234, 32'h5678, 2'b00}) begin
            errors++; $display("FAIL op6_ignored got hi=%h lo=%h busy=%b done=%b exp 00001234 00005678 0 0",
                               bus.hi, bus.lo, bus.busy, bus.done);
        end
        m_hi = 32'h1234; m_lo = 32'h5678;
        @(posedge clk); #1;
    endtask

    task automatic test_cancel();
        logic [63:0] res, exp_v;
        int          lat, st;
        logic [31:0] a, b;
        // Cancel beats an MTHI accept in the same cycle.
        bus.start = 1'b1; bus.op = 3'd4; bus.src_a = 32'hDEAD_0001; bus.cancel = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.cancel = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.hi !== m_hi) begin
            errors++; $display("FAIL cancel_vs_accept got hi=%h exp %h", bus.hi, m_hi);
        end
        @(posedge clk); #1;
        // DIV cancelled at step 10.
        a = $urandom; b = 32'($urandom_range(1, 1000));
        bus.start = 1'b1; bus.op = 3'd2; bus.src_a = a; bus.src_b = b;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (10) begin @(posedge clk); #1; end
        bus.cancel = 1'b1;
        @(posedge clk); #1;
        bus.cancel = 1'b0;
        checks++;
        if ({bus.busy, bus.done, bus.hi, bus.lo} !== {2'b00, m_hi, m_lo}) begin
            errors++; $display("FAIL cancel_div got busy=%b done=%b hi=%h lo=%h exp 0 0 %h %h",
                               bus.busy, bus.done, bus.hi, bus.lo, m_hi, m_lo);
        end
        a = $urandom; b = $urandom;
        exp_v = ref_result(3'd0, a, b);
        run_op(3'd0, a, b, lat, st, res);
        checks++;
        if (lat !== 2 || res !== exp_v) begin
            errors++; $display("FAIL mult_after_cancel got lat=%0d res=%h exp lat=2 res=%h", lat, res, exp_v);
        end
        {m_hi, m_lo} = exp_v;
        // Cancel beats completion of a MULT.
        bus.start = 1'b1; bus.op = 3'd1; bus.src_a = $urandom; bus.src_b = $urandom;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.cancel = 1'b1;
        @(posedge clk); #1;
        bus.cancel = 1'b0;
        checks++;
        if ({bus.busy, bus.done, bus.hi, bus.lo} !== {2'b00, m_hi, m_lo}) begin
            errors++; $display("FAIL cancel_mul got busy=%b done=%b hi=%h lo=%h exp 0 0 %h %h",
                               bus.busy, bus.done, bus.hi, bus.lo, m_hi, m_lo);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        logic [31:0] a, b;
        logic [63:0] res, exp_v;
        int          lat, st, seen;
        // start held high through the done cycle.
        a = $urandom; b = $urandom;
        exp_v = ref_result(3'd1, a, b);
        bus.start = 1'b1; bus.op = 3'd1; bus.src_a = a; bus.src_b = b;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.done) begin
                seen = i;
                res = {bus.hi, bus.lo};
                checks++;
                if (bus.stallreq !== 1'b0) begin
                    errors++; $display("FAIL stall_in_done got %b exp 0", bus.stallreq);
                end
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        bus.start = 1'b0;
        checks++;
        if (seen !== 2 || res !== exp_v) begin
            errors++; $display("FAIL held_start_result got lat=%0d res=%h exp lat=2 res=%h", seen, res, exp_v);
        end
        @(negedge clk);
        checks++;
        if ({bus.busy, bus.done} !== 2'b00) begin
            errors++; $display("FAIL held_start_single got busy=%b done=%b exp 0 0", bus.busy, bus.done);
        end
        {m_hi, m_lo} = exp_v;
        @(posedge clk); #1;
        // DIV then MULT accepted in the cycle right after done.
        a = $urandom; b = 32'($urandom_range(1, 50));
        exp_v = ref_result(3'd3, a, b);
        run_op(3'd3, a, b, lat, st, res);
        checks++;
        if (lat !== 34 || res !== exp_v) begin
            errors++; $display("FAIL b2b_div got lat=%0d res=%h exp lat=34 res=%h", lat, res, exp_v);
        end
        a = $urandom; b = $urandom;
        exp_v = ref_result(3'd0, a, b);
        run_op(3'd0, a, b, lat, st, res);
        checks++;
        if (lat !== 2 || st !== 2 || res !== exp_v) begin
            errors++; $display("FAIL b2b_mul got lat=%0d stalls=%0d res=%h exp lat=2 stalls=2 res=%h",
                               lat, st, res, exp_v);
        end
        {m_hi, m_lo} = exp_v;
    endtask

    task automatic test_rst_mid_div();
        bus.start = 1'b1; bus.op = 3'd4; bus.src_a = 32'hA5A5_0001;
        @(posedge clk); #1;
        bus.op = 3'd5; bus.src_a = 32'h5A5A_0002;
        @(posedge clk); #1;
        bus.op = 3'd2; bus.src_a = $urandom; bus.src_b = 32'd3;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (15) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.hi, bus.lo, bus.busy, bus.done, bus.stallreq} !== 67'd0) begin
            errors++; $display("FAIL rst_mid_div got hi=%h lo=%h busy=%b done=%b stall=%b exp all zero",
                               bus.hi, bus.lo, bus.busy, bus.done, bus.stallreq);
        end
        m_hi = 32'd0; m_lo = 32'd0;
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_mthi_mtlo();
        test_cancel();
        test_back_to_back();
        test_rst_mid_div();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mdu_ctrl.md
# mdu_ctrl

Multiply/divide sequencer for the EX stage of the 5-stage MIPS pipeline. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO requests from EX and owns the architectural HI/LO registers. It runs a 32-step restoring divider and a one-cycle multiplier. While an operation is in flight it drives `stallreq` into the stall controller, so the issuing instruction is held in EX until `done`.

## Interface
Parameters:
- `DIV_STEPS`, default 32: divider iterations; fixed to the operand width and not meant to be overridden.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `start` in 1: EX holds a valid MDU instruction this cycle.
- `op` in 3: operation code from the shared defines. 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; 6 and 7 are ignored.
- `src_a` in 32: rs operand (dividend / multiplicand / MTHI-MTLO data).
- `src_b` in 32: rt operand (divisor / multiplier).
- `cancel` in 1: synchronous flush of any in-flight operation.
- `stallreq` out 1: request to freeze IF..EX.
- `busy` out 1: state is not IDLE.
- `done` out 1: one-cycle pulse; HI/LO hold the new result in this same cycle.
- `hi` out 32: HI register.
- `lo` out 32: LO register.

## Operation
- States: IDLE, MUL, DIV_RUN, DIV_FIX.
- Accept condition: state IDLE & `start` & ~`done` & ~`cancel`. `start` is ignored while busy, and also in the `done` cycle, because the completed instruction is still in EX during that cycle.
- MTHI/MTLO: on accept, `hi` or `lo` takes `src_a` at that edge. No state change, no stall, no `done`.
- MULT/MULTU: on accept, latch the operands and go to MUL.
  - In MUL, compute the 64-bit product (signed for MULT, unsigned for MULTU).
  - At the end of MUL, write {hi,lo} = product, set `done`, return to IDLE.
- DIV/DIVU: on accept, latch operand magnitudes (absolute values for DIV), the quotient sign a^b, the remainder sign a[31], and a divisor-zero flag. Then go to DIV_RUN with step count 0.
  - One step per DIV_RUN cycle on the 64-bit {rem,quo} register: shift left 1; if rem[31:0]-with-carry (33-bit compare) ≥ divisor, subtract and set quo[0].
  - After step 31, go to DIV_FIX.
  - In DIV_FIX: negate quo if the quotient sign is set, and negate rem if the remainder sign is set (DIV only).
  - Divisor zero, both DIV and DIVU: lo=0xFFFFFFFF, hi=src_a.
  - At the end of DIV_FIX, write hi=rem, lo=quo, set `done`, return to IDLE.
- 0x80000000 DIV 0xFFFFFFFF gives lo=0x80000000, hi=0 through natural 32-bit wrap; it is not trapped.
- `stallreq` = `busy` | (`start` & op∈{0..3} & ~`done`), combinational.
- `cancel`: state becomes IDLE at the next edge. HI/LO are not written and `done` stays 0. Cancel has priority over accept and over completion in the same cycle.
- `rst`: state IDLE, step count 0, hi=lo=0, done=0, stallreq=0 (start is assumed low during reset), busy=0.

## Timing
- Accept edge is E0.
- MUL: busy during E0..E1; hi/lo written and `done`=1 in the cycle after E1. Stall cycles seen by the pipeline: 2.
- DIV/DIVU: DIV_RUN occupies 32 cycles and DIV_FIX 1 cycle; `done`=1 in the cycle after E33. Total stall: 34 cycles.
- `done` is registered, high for exactly one cycle. `stallreq` falls in that same cycle, so EX advances at the edge closing the `done` cycle.
- MTHI/MTLO write is visible at `hi`/`lo` the cycle after E0.
- A new MDU request is accepted at the earliest in the cycle after `done`, back-to-back with no idle cycle.

## Structure
- `lib/defines.vh` gains:
  - `MDU_OP_WD` = 3 and the six op codes.
  - `MDU_ST_*` state encodings.
  - An MDU field extension to `ID_TO_EX_WD`, so ID decodes `op` and EX drives `start`.
- One sub-module, `mdu_div_step`: a combinational single restoring step, taking {rem,quo} and the divisor and returning the next {rem,quo}. The multiplier stays inline.
- Top-level wiring: EX instantiates `mdu_ctrl`; its `stallreq` is ORed into the stall controller; `hi`/`lo` feed MFHI/MFLO forwarding.

## Test plan
- MULT 0xFFFFFFFE × 0x00000003 → after 2 stall cycles `done`, hi=0xFFFFFFFF, lo=0xFFFFFFFA. MULTU of the same operands → hi=0x00000002, lo=0xFFFFFFFA.
- DIV −7 / 2 → `done` exactly 34 cycles after accept, lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 100/7 → lo=14, hi=2.
- DIVU 5/0 → lo=0xFFFFFFFF, hi=5. DIV 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0.
- MTHI 0x1234 then MTLO 0x5678 on consecutive cycles → no `stallreq`, hi=0x1234, lo=0x5678 one cycle after each accept.
- DIV in flight, `cancel` pulsed at step 10 → IDLE next cycle, no `done`, hi/lo unchanged. A new MULT in the following cycle is accepted normally.
- `start` held high across `done` → only one operation executes. `rst` asserted mid-DIV → hi=lo=0, busy=0 next cycle.
